// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the MEM pipeline stage.
//   - MEMOP_* : 4-bit memory operation codes carried in ex_mem
//   - ST_*    : FSM state encodings (IDLE/BUSY/DONE), also seen on dbg_state
//   - STALL_NO, ZERO_DATA, ZERO_DATA_ADDR : pipeline-wide constants
//   - mem_size_e / memop_size() : access width implied by an op code
package mem_access_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LB   = 4'd1;
    localparam logic [3:0] MEMOP_LBU  = 4'd2;
    localparam logic [3:0] MEMOP_LH   = 4'd3;
    localparam logic [3:0] MEMOP_LHU  = 4'd4;
    localparam logic [3:0] MEMOP_LW   = 4'd5;
    localparam logic [3:0] MEMOP_SB   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SW   = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic STALL_NO = 1'b0;

    localparam logic [DATA_W-1:0]     ZERO_DATA      = '0;
    localparam logic [REG_ADDR_W-1:0] ZERO_DATA_ADDR = '0;

    typedef enum logic [1:0] {
        SIZE_NONE = 2'd0,
        SIZE_B    = 2'd1,
        SIZE_H    = 2'd2,
        SIZE_W    = 2'd3
    } mem_size_e;

    // Unknown op codes map to SIZE_NONE so they behave like an ALU op.
    function automatic mem_size_e memop_size(input logic [3:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: memop_size = SIZE_B;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: memop_size = SIZE_H;
            MEMOP_LW, MEMOP_SW:            memop_size = SIZE_W;
            default:                       memop_size = SIZE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: req/ack data bus between the MEM stage and the data memory.
//   req   : access requested; held with we/addr/be/wdata stable until ack
//   we    : 1 = store, 0 = load
//   addr  : word address, [1:0] always zero
//   be    : little-endian byte enables
//   wdata : store data, lane-replicated
//   rdata : read data, valid in the cycle ack=1
//   ack   : single-cycle completion pulse
// Handshake: the master raises req with a stable payload; the slave answers
// with exactly one ack pulse; req drops at the edge that samples ack. A
// request may be abandoned by reset, and an ack with no pending req is ignored.
interface mem_access_if
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_fmt.sv
// mem_access_fmt: combinational lane formatting for the MEM stage.
//   memop    in  : operation code
//   addr_lo  in  : byte offset within the word
//   sdata    in  : raw store data (rt)
//   rdata    in  : captured read word
//   be       out : byte enables for the access
//   wdata    out : store data replicated across lanes
//   ldata    out : selected and sign/zero-extended load result
//   misalign out: half/word access not naturally aligned
//   is_mem   out : op touches memory
//   is_store out: op is a store
module mem_access_fmt
    import mem_access_pkg::*;
(
    input  logic [3:0]        memop,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] sdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ldata,
    output logic              misalign,
    output logic              is_mem,
    output logic              is_store
);
    mem_size_e size;
    logic      sext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        size     = memop_size(memop);
        sext     = (memop == MEMOP_LB) || (memop == MEMOP_LH);
        is_mem   = (size != SIZE_NONE);
        is_store = (memop == MEMOP_SB) || (memop == MEMOP_SH) || (memop == MEMOP_SW);

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        be       = 4'b0000;
        wdata    = sdata;
        ldata    = rdata;
        misalign = 1'b0;
        case (size)
            SIZE_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sdata[15:0]}};
                ldata    = {{16{sext & half_sel[15]}}, half_sel};
            end
            SIZE_W: begin
                misalign = (addr_lo != 2'b00);
                be       = 4'b1111;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Performs the load/store held in ex_mem over
// the req/ack bus and drives the write-back triple into mem_wb.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : STALL_NO = instruction in MEM advances at this edge
//   ex_*            : instruction fields from ex_mem
//   mem_wdata/waddr/we : write-back triple to mem_wb
//   mem_misalign    : address error for the current instruction
//   stall_req       : freeze the pipeline through MEM
//   dbg_state       : current FSM state (ST_IDLE/ST_BUSY/ST_DONE)
//   bus             : data bus, master side
// ALU ops pass through combinationally. An aligned memory op spends one IDLE
// cycle launching the request, BUSY until ack, then DONE until the pipeline
// advances.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic                  ex_we,
    input  logic [3:0]            ex_memop,
    input  logic [ADDR_W-1:0]     ex_maddr,
    input  logic [DATA_W-1:0]     ex_sdata,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [REG_ADDR_W-1:0] mem_waddr,
    output logic                  mem_we,
    output logic                  mem_misalign,
    output logic                  stall_req,
    output logic [1:0]            dbg_state,
    mem_access_if.master          bus
);
    logic [1:0]        state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [3:0]        fmt_be;
    logic [DATA_W-1:0] fmt_wdata;
    logic [DATA_W-1:0] fmt_ldata;
    logic              fmt_misalign;
    logic              fmt_is_mem;
    logic              fmt_is_store;
    logic              go;

    mem_access_fmt u_fmt (
        .memop    (ex_memop),
        .addr_lo  (ex_maddr[1:0]),
        .sdata    (ex_sdata),
        .rdata    (rdata_q),
        .be       (fmt_be),
        .wdata    (fmt_wdata),
        .ldata    (fmt_ldata),
        .misalign (fmt_misalign),
        .is_mem   (fmt_is_mem),
        .is_store (fmt_is_store)
    );

    assign go = fmt_is_mem & ~fmt_misalign;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d     = ST_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = fmt_is_store;
                    bus_addr_d  = {ex_maddr[ADDR_W-1:2], 2'b00};
                    bus_be_d    = fmt_be;
                    bus_wdata_d = fmt_wdata;
                end
            end
            ST_BUSY: begin
                // Payload registers keep their value after ack; only req drops.
                if (bus.ack) begin
                    rdata_d   = bus.rdata;
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (stall == STALL_NO) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Output mux. ex_mem is frozen while this op is in flight, so ex_* still
    // describe it in DONE (including the lane offset for load extraction).
    always_comb begin
        mem_wdata    = ex_wdata;
        mem_waddr    = ex_waddr;
        mem_we       = ex_we;
        mem_misalign = fmt_misalign;
        stall_req    = 1'b0;
        if (fmt_is_mem) begin
            mem_we = 1'b0;
            if (!fmt_misalign) begin
                stall_req = (state_q != ST_DONE);
                if (state_q == ST_DONE) begin
                    mem_we = ex_we;
                    if (!fmt_is_store) begin
                        mem_wdata = fmt_ldata;
                    end
                end
            end
        end
        if (rst) begin
            mem_wdata    = ZERO_DATA;
            mem_waddr    = ZERO_DATA_ADDR;
            mem_we       = 1'b0;
            mem_misalign = 1'b0;
            stall_req    = 1'b0;
        end
    end

    assign dbg_state = state_q;
    assign bus.req   = bus_req_q;
    assign bus.we    = bus_we_q;
    assign bus.addr  = bus_addr_q;
    assign bus.be    = bus_be_q;
    assign bus.wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        stall;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_sdata;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic        mem_misalign;
    logic        stall_req;
    logic [1:0]  dbg_state;

    mem_access_if #(.ADDR_W(32)) bus_if ();

    mem_access #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_wdata     (ex_wdata),
        .ex_waddr     (ex_waddr),
        .ex_we        (ex_we),
        .ex_memop     (ex_memop),
        .ex_maddr     (ex_maddr),
        .ex_sdata     (ex_sdata),
        .mem_wdata    (mem_wdata),
        .mem_waddr    (mem_waddr),
        .mem_we       (mem_we),
        .mem_misalign (mem_misalign),
        .stall_req    (stall_req),
        .dbg_state    (dbg_state),
        .bus          (bus_if)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a memory op in IDLE, confirm the stall request, enter BUSY.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata);
        ex_memop = op;
        ex_maddr = addr;
        ex_sdata = sdata;
        #1;
        check({tag, "_idle_stall_req"}, stall_req, 1'b1);
        check({tag, "_idle_mem_we"}, mem_we, 1'b0);
        tick();
        check({tag, "_busy_state"}, dbg_state, ST_BUSY);
    endtask

    // Slave answers with one ack pulse; rdata scrambled afterwards.
    task automatic ack(input logic [31:0] rdata);
        bus_if.rdata = rdata;
        bus_if.ack   = 1'b1;
        tick();
        bus_if.ack   = 1'b0;
        bus_if.rdata = $urandom;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        stall        = 1'b0;
        ex_wdata     = 32'h0000_0055;
        ex_waddr     = 5'd3;
        ex_we        = 1'b1;
        ex_memop     = MEMOP_LW;
        ex_maddr     = 32'h0000_0100;
        ex_sdata     = 32'h0;
        bus_if.rdata = 32'h0;
        bus_if.ack   = 1'b0;

        #2;
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_waddr", mem_waddr, 5'd0);
        check("rst_stall_req", stall_req, 1'b0);
        check("rst_bus_req", bus_if.req, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);

        tick();
        tick();
        ex_memop = MEMOP_NONE;
        rst      = 1'b0;
        #1;

        // ALU pass-through
        ex_wdata = 32'h1111_2222;
        ex_waddr = 5'd7;
        ex_we    = 1'b1;
        #1;
        check("alu_wdata", mem_wdata, 32'h1111_2222);
        check("alu_waddr", mem_waddr, 5'd7);
        check("alu_we", mem_we, 1'b1);
        check("alu_stall_req", stall_req, 1'b0);

        // Stray ack in IDLE must be ignored
        bus_if.ack   = 1'b1;
        bus_if.rdata = 32'h5A5A_5A5A;
        tick();
        bus_if.ack   = 1'b0;
        check("stray_ack_state", dbg_state, ST_IDLE);
        check("stray_ack_bus_req", bus_if.req, 1'b0);

        // 1. LW 0x100, ack in first BUSY cycle
        ex_waddr = 5'd4;
        issue("lw", MEMOP_LW, 32'h0000_0100, 32'h0);
        check("lw_bus_req", bus_if.req, 1'b1);
        check("lw_bus_we", bus_if.we, 1'b0);
        check("lw_bus_addr", bus_if.addr, 32'h0000_0100);
        check("lw_bus_be", bus_if.be, 4'hF);
        check("lw_busy_stall_req", stall_req, 1'b1);
        check("lw_busy_mem_we", mem_we, 1'b0);
        ack(32'hDEAD_BEEF);
        check("lw_done_state", dbg_state, ST_DONE);
        check("lw_done_stall_req", stall_req, 1'b0);
        check("lw_done_bus_req", bus_if.req, 1'b0);
        check("lw_done_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("lw_done_we", mem_we, 1'b1);
        check("lw_done_waddr", mem_waddr, 5'd4);
        tick();
        check("lw_back_idle", dbg_state, ST_IDLE);

        // 2. LB / LBU 0x103
        issue("lb", MEMOP_LB, 32'h0000_0103, 32'h0);
        check("lb_bus_be", bus_if.be, 4'b1000);
        check("lb_bus_addr", bus_if.addr, 32'h0000_0100);
        ack(32'h80FF_FF7F);
        check("lb_wdata", mem_wdata, 32'hFFFF_FF80);
        tick();
        issue("lbu", MEMOP_LBU, 32'h0000_0103, 32'h0);
        ack(32'h80FF_FF7F);
        check("lbu_wdata", mem_wdata, 32'h0000_0080);
        tick();

        // 3. SH 0x202
        ex_we    = 1'b0;
        ex_wdata = 32'h0000_0202;
        issue("sh", MEMOP_SH, 32'h0000_0202, 32'h1234_ABCD);
        check("sh_bus_we", bus_if.we, 1'b1);
        check("sh_bus_addr", bus_if.addr, 32'h0000_0200);
        check("sh_bus_be", bus_if.be, 4'b1100);
        check("sh_bus_wdata", bus_if.wdata, 32'hABCD_ABCD);
        ack(32'h0);
        check("sh_done_we", mem_we, 1'b0);
        check("sh_done_wdata", mem_wdata, 32'h0000_0202);
        tick();

        // SB 0x201 byte replication
        issue("sb", MEMOP_SB, 32'h0000_0201, 32'h0000_00A5);
        check("sb_bus_be", bus_if.be, 4'b0010);
        check("sb_bus_wdata", bus_if.wdata, 32'hA5A5_A5A5);
        ack(32'h0);
        tick();

        // 4. LW 0x101 misaligned
        ex_we    = 1'b1;
        ex_memop = MEMOP_LW;
        ex_maddr = 32'h0000_0101;
        #1;
        check("mis_flag", mem_misalign, 1'b1);
        check("mis_stall_req", stall_req, 1'b0);
        check("mis_mem_we", mem_we, 1'b0);
        tick();
        check("mis_bus_req_1", bus_if.req, 1'b0);
        check("mis_state", dbg_state, ST_IDLE);
        tick();
        check("mis_bus_req_2", bus_if.req, 1'b0);

        // 5. LH 0x100, ack in the 5th BUSY cycle, stall held in DONE
        ex_waddr = 5'd12;
        issue("lh", MEMOP_LH, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_if.rdata = $urandom;
            check("lh_wait_bus_req", bus_if.req, 1'b1);
            check("lh_wait_bus_be", bus_if.be, 4'b0011);
            check("lh_wait_bus_addr", bus_if.addr, 32'h0000_0100);
            check("lh_wait_stall_req", stall_req, 1'b1);
            check("lh_wait_mem_we", mem_we, 1'b0);
            tick();
        end
        check("lh_last_busy_state", dbg_state, ST_BUSY);
        stall = 1'b1;
        ack(32'h1234_8765);
        for (int i = 0; i < 3; i++) begin
            check("lh_done_state", dbg_state, ST_DONE);
            check("lh_done_wdata", mem_wdata, 32'hFFFF_8765);
            check("lh_done_we", mem_we, 1'b1);
            check("lh_done_stall_req", stall_req, 1'b0);
            check("lh_done_bus_be", bus_if.be, 4'b0011);
            if (i == 2) stall = 1'b0;
            tick();
        end
        check("lh_back_idle", dbg_state, ST_IDLE);

        // 6. reset pulse while BUSY
        issue("rstb", MEMOP_LW, 32'h0000_0104, 32'h0);
        check("rstb_bus_req_before", bus_if.req, 1'b1);
        rst = 1'b1;
        #1;
        check("rstb_bus_req_async", bus_if.req, 1'b0);
        check("rstb_stall_req", stall_req, 1'b0);
        check("rstb_state", dbg_state, ST_IDLE);
        tick();
        rst      = 1'b0;
        ex_memop = MEMOP_NONE;
        ex_wdata = 32'hCAFE_0001;
        ex_waddr = 5'd9;
        ex_we    = 1'b1;
        #1;
        check("post_rst_wdata", mem_wdata, 32'hCAFE_0001);
        check("post_rst_waddr", mem_waddr, 5'd9);
        check("post_rst_we", mem_we, 1'b1);
        check("post_rst_stall_req", stall_req, 1'b0);
        tick();
        check("post_rst_state", dbg_state, ST_IDLE);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
